// File: rtl/mls_checker.sv
// Receive-side MLS checker: self-synchronising predictor for orders W = 6..13,
// with lock detection, windowed loss-of-lock and saturating BER counters.
module mls_checker #(
    parameter int CNT_W   = 32,
    parameter int ERR_WIN = 64,
    parameter int ERR_THR = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic [2:0]       order_i,
    input  logic             bit_i,
    input  logic             bit_vld_i,
    input  logic             clr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic             wrap_o,
    output logic             lost_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] bit_cnt_o
);

    localparam int WIN_W = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
    localparam int THR_W = $clog2(ERR_THR + 1);

    typedef enum logic [1:0] {IDLE, FILL, VERIFY, LOCKED} state_t;

    state_t            state_reg, state_next;
    logic [12:0]       hist_reg, hist_next;
    logic [2:0]        order_reg;
    logic [4:0]        seq_cnt_reg, seq_cnt_next;
    logic [WIN_W-1:0]  win_cnt_reg, win_cnt_next;
    logic [THR_W-1:0]  win_err_reg, win_err_next, win_err_inc;
    logic [CNT_W-1:0]  err_cnt_reg, err_cnt_next;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic              err_reg, err_next;
    logic              wrap_reg, wrap_next;
    logic              lost_reg, lost_next;
    logic              locked_reg;

    logic [12:0]       mask;
    logic [3:0]        width;
    logic [12:0]       wmask;
    logic [12:0]       hist_shift;
    logic              pred;
    logic              match;

    // Feedback taps: bit i of the mask is the bit received i+1 valid bits ago.
    always_comb begin
        mask  = 13'h0;
        width = 4'd6;
        case (order_reg)
            3'd0: begin mask = 13'b0000000110000; width = 4'd6;  end
            3'd1: begin mask = 13'b0000001100000; width = 4'd7;  end
            3'd2: begin mask = 13'b0000010111000; width = 4'd8;  end
            3'd3: begin mask = 13'b0000100010000; width = 4'd9;  end
            3'd4: begin mask = 13'b0001001000000; width = 4'd10; end
            3'd5: begin mask = 13'b0010100000000; width = 4'd11; end
            3'd6: begin mask = 13'b0100000101001; width = 4'd12; end
            default: begin mask = 13'b1000000001101; width = 4'd13; end
        endcase
    end

    // For W = 13 the shift overflows to zero, so the subtraction yields all-ones.
    assign wmask      = (13'd1 << width) - 13'd1;
    assign hist_shift = {hist_reg[11:0], bit_i};
    assign pred       = ^(hist_reg & mask);
    assign match      = (bit_i == pred);
    assign win_err_inc = win_err_reg + {{(THR_W-1){1'b0}}, ~match};

    always_comb begin
        state_next   = state_reg;
        hist_next    = hist_reg;
        seq_cnt_next = seq_cnt_reg;
        win_cnt_next = win_cnt_reg;
        win_err_next = win_err_reg;
        err_cnt_next = err_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        err_next     = 1'b0;
        wrap_next    = 1'b0;
        lost_next    = 1'b0;

        if (!en) begin
            state_next = IDLE;
        end else if (state_reg == IDLE) begin
            state_next   = FILL;
            seq_cnt_next = 5'd0;
        end else if (order_i != order_reg) begin
            state_next   = FILL;
            hist_next    = 13'h0;
            seq_cnt_next = 5'd0;
            lost_next    = (state_reg == LOCKED);
        end else if (bit_vld_i) begin
            hist_next = hist_shift;
            case (state_reg)
                FILL: begin
                    if (seq_cnt_reg + 5'd1 == {1'b0, width}) begin
                        state_next   = VERIFY;
                        seq_cnt_next = 5'd0;
                    end else begin
                        seq_cnt_next = seq_cnt_reg + 5'd1;
                    end
                end
                VERIFY: begin
                    if (!match) begin
                        state_next   = FILL;
                        seq_cnt_next = 5'd0;
                    end else if (seq_cnt_reg + 5'd1 == {width, 1'b0}) begin
                        state_next   = LOCKED;
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        seq_cnt_next = seq_cnt_reg + 5'd1;
                    end
                end
                LOCKED: begin
                    wrap_next = ((hist_shift | ~wmask) == 13'h1FFF);
                    if (bit_cnt_reg != {CNT_W{1'b1}})
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (!match) begin
                        err_next = 1'b1;
                        if (err_cnt_reg != {CNT_W{1'b1}})
                            err_cnt_next = err_cnt_reg + 1'b1;
                    end
                    if (win_err_inc == THR_W'(ERR_THR)) begin
                        state_next   = FILL;
                        seq_cnt_next = 5'd0;
                        lost_next    = 1'b1;
                    end else if (win_cnt_reg == WIN_W'(ERR_WIN - 1)) begin
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_cnt_next = win_cnt_reg + 1'b1;
                        win_err_next = win_err_inc;
                    end
                end
                default: ;
            endcase
        end

        // A clear wins over an increment landing in the same cycle.
        if (clr_i) begin
            err_cnt_next = '0;
            bit_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg   <= IDLE;
            hist_reg    <= 13'h0;
            order_reg   <= 3'd0;
            seq_cnt_reg <= 5'd0;
            win_cnt_reg <= '0;
            win_err_reg <= '0;
            err_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            err_reg     <= 1'b0;
            wrap_reg    <= 1'b0;
            lost_reg    <= 1'b0;
            locked_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hist_reg    <= hist_next;
            order_reg   <= order_i;
            seq_cnt_reg <= seq_cnt_next;
            win_cnt_reg <= win_cnt_next;
            win_err_reg <= win_err_next;
            err_cnt_reg <= err_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            err_reg     <= err_next;
            wrap_reg    <= wrap_next;
            lost_reg    <= lost_next;
            locked_reg  <= (state_next == LOCKED);
        end
    end

    assign locked_o  = locked_reg;
    assign err_o     = err_reg;
    assign wrap_o    = wrap_reg;
    assign lost_o    = lost_reg;
    assign err_cnt_o = err_cnt_reg;
    assign bit_cnt_o = bit_cnt_reg;

endmodule

// File: doc/mls_checker.md
Name: mls_checker

Overview:
- Receive-side checker for the maximum-length-sequence (MLS) stimulus family driven to the DAC.
- Takes the bit stream recovered from the ADC path and self-synchronises a local predictor for the selected order.
- Declares lock, then counts bit errors, valid bits and sequence periods for BER and impulse-response capture control.
- Sits after the bit slicer; counters are read by the AXI register block.

Parameters:
- CNT_W, 32, width of the err_cnt_o and bit_cnt_o counters; counters saturate.
- ERR_WIN, 64, length in valid bits of the loss-of-lock error window.
- ERR_THR, 8, number of errors within one window that forces resynchronisation.

Ports:
- clk  in  1  system clock
- srst  in  1  synchronous reset, active-high
- en  in  1  block enable; low forces IDLE, counters hold
- order_i  in  3  sequence order: 0..7 selects width W = 6..13
- bit_i  in  1  received bit, qualified by bit_vld_i
- bit_vld_i  in  1  bit_i valid this cycle
- clr_i  in  1  clear err_cnt_o and bit_cnt_o
- locked_o  out  1  predictor locked
- err_o  out  1  one-cycle pulse: mismatched bit while LOCKED
- wrap_o  out  1  one-cycle pulse at each sequence period boundary while LOCKED
- lost_o  out  1  one-cycle pulse on loss of lock
- err_cnt_o  out  CNT_W  errors counted while LOCKED
- bit_cnt_o  out  CNT_W  valid bits counted while LOCKED

Behaviour:
- Clocking and reset: one clock. srst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, history 0.
- Polynomial masks, order 0..7, bit i = delay i+1:
  - 6'b110000, 7'b1100000, 8'b10111000, 9'b100010000
  - 10'b1001000000, 11'b10100000000, 12'b100000101001, 13'b1000000001101
- Predictor:
  - 13-bit history h; h[0] is the most recent valid bit.
  - Every valid bit shifts in (h <= {h[11:0], bit_i}) in all states except IDLE.
  - Prediction p = XOR-reduce(h[W-1:0] & mask), evaluated before the shift. match = (bit_i == p).
- State machine (transitions only on bit_vld_i cycles, except the en and order rules):
  - IDLE: entered when en = 0. Goes to FILL with the fill counter cleared when en = 1.
  - FILL: collects W valid bits without checking, then goes to VERIFY.
  - VERIFY: 2W consecutive matches go to LOCKED. Any mismatch goes to FILL, with no lost_o.
  - LOCKED:
    - Every valid bit increments bit_cnt.
    - A mismatch increments err_cnt and pulses err_o.
    - Window counter runs over ERR_WIN valid bits; window error count is restarted at window wrap.
    - When window errors reach ERR_THR: go to FILL, pulse lost_o, drop locked_o.
- order_i change (registered copy compared each cycle) in any non-IDLE state: go to FILL, clear history. If the change happens in LOCKED, pulse lost_o.
- locked_o = (state == LOCKED), registered.
- wrap_o: in LOCKED, after the shift, the new h[W-1:0] is all-ones. This gives one pulse per 2^W-1 valid bits.
- Latency: err_o, wrap_o, lost_o, locked_o and counter updates appear on the clock edge that follows the bit_vld_i cycle.
- Counters:
  - Saturate at all-ones; no wrap.
  - clr_i has priority over any simultaneous increment (result 0).
  - Counters hold through IDLE, FILL and VERIFY.
- Single-bit error signature: one channel error produces 1 + (number of mask taps) mismatches as it passes through the history. These are all counted.
- Reset mid-operation: next cycle equals the reset state; counters are cleared.

Test Plan:
- Order 0, error-free stream from a generator seeded 6'b111111, bit_vld_i every cycle -> locked_o rises after the 18th valid bit (6 fill + 12 verify). wrap_o every 63 bits. err_cnt_o stays 0. bit_cnt_o = 630 after 630 locked bits.
- Order 0 locked, flip one bit -> err_o pulses 3 times (bit itself, delays 5 and 6), err_cnt_o = 3, locked_o stays 1.
- Order 2 (W=8) locked, 8 consecutive inverted bits inside one 64-bit window -> lost_o one pulse, locked_o = 0, relock 24 valid bits after clean data resumes.
- Order 7 (W=13), bit_vld_i toggling every other cycle -> lock after 39 valid bits (78 cycles). wrap_o spacing 8191 valid bits.
- Locked at order 1, change order_i to 3 -> lost_o pulse, state FILL. Clean order-3 stream -> lock after 27 valid bits. Counters are not cleared.
- clr_i asserted in the same cycle as a mismatch -> err_cnt_o = 0. Preload near saturation (CNT_W = 4 build) -> err_cnt_o holds at 15. srst mid-LOCKED -> all outputs 0 next cycle.
